// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - MULDIV_Op encodings (MD_*)
//   - HI/LO select constants for MTHL/MFHL
//   - default busy-cycle counts for multiply and divide
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic HILO_LO = 1'b0;
    localparam logic HILO_HI = 1'b1;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    localparam int unsigned CNT_W = 4;

    // True for the two signed operations.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational multiply/divide datapath.
//   a, b        : operands (a = multiplicand/dividend, b = multiplier/divisor)
//   op          : MULDIV_Op encoding (see muldiv_pkg)
//   hi_n, lo_n  : result for the HI/LO registers
//   div_by_zero : divide op with b == 0; caller must leave HI/LO untouched
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        div_by_zero
);

    logic        is_signed;
    logic        is_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;

    always_comb begin
        is_signed = op_is_signed(op);
        is_div    = op[1];

        // Low 64 bits of the product of sign/zero-extended operands equal the
        // true signed/unsigned 64-bit product.
        a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = a_ext * b_ext;

        // Signed divide is done on magnitudes; 0x80000000 / -1 falls out
        // naturally as quotient 0x80000000, remainder 0.
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_abs = a_neg ? (~a + 32'd1) : a;
        b_abs = b_neg ? (~b + 32'd1) : b;

        div_by_zero = is_div & (b == 32'd0);

        uq = 32'd0;
        ur = 32'd0;
        if (b_abs != 32'd0) begin
            uq = a_abs / b_abs;
            ur = a_abs % b_abs;
        end

        // Quotient truncates toward zero; remainder takes the dividend's sign.
        q = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        r = a_neg ? (~ur + 32'd1) : ur;

        if (is_div) begin
            hi_n = r;
            lo_n = q;
        end else begin
            hi_n = prod[63:32];
            lo_n = prod[31:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at the accepting edge and held pending; a busy
// counter models mult/div latency and HI/LO update when it reaches zero.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : launch muldiv_op on rs_val/rt_val this cycle
//   muldiv_op   : 00 mult, 01 multu, 10 div, 11 divu
//   hilo_sel    : 0 = LO, 1 = HI (target of mthl, source of hilo_rdata)
//   mthl        : write rs_val into the selected register
//   cancel      : E-stage flush; suppresses start and mthl this cycle
//   rs_val      : operand A
//   rt_val      : operand B
//   busy        : to hazard logic; high in the start cycle and while counting
//   hilo_rdata  : selected register contents (MFHL)
//   hi_out      : HI register
//   lo_out      : LO register
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  muldiv_op,
    input  logic        hilo_sel,
    input  logic        mthl,
    input  logic        cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dbz_q, pend_dbz_d;

    logic        busy_q;
    logic        start_ok;
    logic        mthl_ok;
    logic [31:0] core_hi;
    logic [31:0] core_lo;
    logic        core_dbz;

    muldiv_core u_core (
        .a           (rs_val),
        .b           (rt_val),
        .op          (muldiv_op),
        .hi_n        (core_hi),
        .lo_n        (core_lo),
        .div_by_zero (core_dbz)
    );

    assign busy_q   = (count_q != '0);
    assign start_ok = start & ~cancel & ~busy_q;
    // start has priority over mthl in the same cycle.
    assign mthl_ok  = mthl & ~cancel & ~busy_q & ~start;

    always_comb begin
        count_d    = count_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_dbz_d = pend_dbz_q;

        if (start_ok) begin
            count_d    = muldiv_op[1] ? DIV_CNT : MULT_CNT;
            pend_hi_d  = core_hi;
            pend_lo_d  = core_lo;
            pend_dbz_d = core_dbz;
        end else if (busy_q) begin
            count_d = count_q - 1'b1;
            // Last busy cycle: commit unless the divisor was zero.
            if (count_q == CNT_W'(1) && !pend_dbz_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (mthl_ok) begin
            if (hilo_sel == HILO_HI) begin
                hi_d = rs_val;
            end else begin
                lo_d = rs_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi_q  <= 32'd0;
            pend_lo_q  <= 32'd0;
            pend_dbz_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_dbz_q <= pend_dbz_d;
        end
    end

    // Gated by rst_n so busy reads low throughout reset.
    assign busy       = rst_n & ((start & ~cancel) | busy_q);
    assign hilo_rdata = (hilo_sel == HILO_HI) ? hi_q : lo_q;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;

    // Hazard logic is expected to keep these from happening; the hardware
    // drops the request either way.
    a_no_start_busy : assert property (@(posedge clk) disable iff (!rst_n)
        !(start && !cancel && busy_q))
        else $warning("muldiv_unit: start dropped while busy");

    a_no_mthl_busy : assert property (@(posedge clk) disable iff (!rst_n)
        !(mthl && !cancel && busy_q))
        else $warning("muldiv_unit: mthl dropped while busy");

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  muldiv_op;
    logic        hilo_sel;
    logic        mthl;
    logic        cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hilo_rdata;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .muldiv_op  (muldiv_op),
        .hilo_sel   (hilo_sel),
        .mthl       (mthl),
        .cancel     (cancel),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .busy       (busy),
        .hilo_rdata (hilo_rdata),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op, check busy over the whole window, then check the result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int busy_cycles;
        start     = 1'b1;
        muldiv_op = op;
        rs_val    = a;
        rt_val    = b;
        #1;
        check_eq({tag, " busy_start"}, 32'(busy), 32'd1);
        tick();
        start  = 1'b0;
        rs_val = 32'h0;
        rt_val = 32'h0;
        busy_cycles = 0;
        while (busy && busy_cycles < 20) begin
            busy_cycles++;
            tick();
        end
        check_eq({tag, " busy_cycles"}, 32'(busy_cycles), 32'(n));
        check_eq({tag, " hi"}, hi_out, exp_hi);
        check_eq({tag, " lo"}, lo_out, exp_lo);
    endtask

    task automatic do_mthl(input logic sel, input logic [31:0] v);
        mthl     = 1'b1;
        hilo_sel = sel;
        rs_val   = v;
        tick();
        mthl = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        muldiv_op = 2'b00;
        hilo_sel  = 1'b0;
        mthl      = 1'b0;
        cancel    = 1'b0;
        rs_val    = 32'h0;
        rt_val    = 32'h0;

        // Reset state, including a start request during reset.
        tick();
        start = 1'b1;
        #1;
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst hi", hi_out, 32'h0);
        check_eq("rst lo", lo_out, 32'h0);
        check_eq("rst rdata", hilo_rdata, 32'h0);
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        run_op("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        // Back-to-back: start in the cycle right after the write edge.
        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("divu", 2'b11, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Divide by zero leaves HI/LO alone after the full latency.
        do_mthl(1'b1, 32'h11);
        do_mthl(1'b0, 32'h22);
        check_eq("mthl hi11", hi_out, 32'h11);
        check_eq("mthl lo22", lo_out, 32'h22);
        run_op("divu0", 2'b11, 32'd5, 32'd0, 10, 32'h11, 32'h22);

        // mthl HI; LO unchanged; read-back through hilo_rdata.
        do_mthl(1'b1, 32'hDEAD_BEEF);
        hilo_sel = 1'b1;
        #1;
        check_eq("mthl hi", hi_out, 32'hDEAD_BEEF);
        check_eq("mthl lo_keep", lo_out, 32'h22);
        check_eq("rdata hi", hilo_rdata, 32'hDEAD_BEEF);
        hilo_sel = 1'b0;
        #1;
        check_eq("rdata lo", hilo_rdata, 32'h22);

        // Cancelled start and cancelled mthl.
        cancel    = 1'b1;
        start     = 1'b1;
        muldiv_op = 2'b01;
        rs_val    = 32'd3;
        rt_val    = 32'd4;
        #1;
        check_eq("cancel busy_comb", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        mthl  = 1'b1;
        hilo_sel = 1'b0;
        tick();
        mthl   = 1'b0;
        cancel = 1'b0;
        check_eq("cancel busy", 32'(busy), 32'd0);
        check_eq("cancel hi", hi_out, 32'hDEAD_BEEF);
        check_eq("cancel lo", lo_out, 32'h22);

        // start/mthl during busy are dropped; original result on schedule.
        start     = 1'b1;
        muldiv_op = 2'b00;
        rs_val    = 32'd2;
        rt_val    = 32'd3;
        tick();
        start = 1'b0;
        tick();
        start     = 1'b1;
        muldiv_op = 2'b11;
        rs_val    = 32'd9;
        rt_val    = 32'd2;
        tick();
        start    = 1'b0;
        mthl     = 1'b1;
        hilo_sel = 1'b1;
        rs_val   = 32'hCAFE_0000;
        tick();
        mthl = 1'b0;
        check_eq("busy_ign busy", 32'(busy), 32'd1);
        check_eq("busy_ign hi_mid", hi_out, 32'hDEAD_BEEF);
        tick();
        check_eq("busy_ign last", 32'(busy), 32'd1);
        tick();
        check_eq("busy_ign done", 32'(busy), 32'd0);
        check_eq("busy_ign hi", hi_out, 32'h0);
        check_eq("busy_ign lo", lo_out, 32'd6);

        // Async reset mid-mult (count = 3): abandoned, HI/LO stay 0.
        start     = 1'b1;
        muldiv_op = 2'b00;
        rs_val    = 32'd7;
        rt_val    = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst busy", 32'(busy), 32'd0);
        check_eq("midrst hi", hi_out, 32'h0);
        check_eq("midrst lo", lo_out, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check_eq("midrst hi_after", hi_out, 32'h0);
        check_eq("midrst lo_after", lo_out, 32'h0);
        check_eq("midrst busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- EX-stage multiply/divide unit; consumes the MULDIV control bundle (Start, MULDIV_Op, HiLo, MTHL, MFHL) and the forwarded operands that the ID/EX pipeline register delivers.
- Owns the architectural HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- Reports busy to hazard logic, which stalls IF/ID and flushes ID/EX for dependent mult/div/mfhi/mflo/mthi/mtlo instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch operation this cycle (from ID/EX Start)
- muldiv_op  input  2  00 mult, 01 multu, 10 div, 11 divu
- hilo_sel  input  1  0 = LO, 1 = HI; selects the target for MTHL and the source for MFHL
- mthl  input  1  write rs_val into the selected HI/LO register
- cancel  input  1  exception/eret flush in E stage; suppresses start and mthl this cycle
- rs_val  input  32  forwarded operand A (dividend / multiplicand)
- rt_val  input  32  forwarded operand B (divisor / multiplier)
- busy  output  1  start & !cancel | busy_q
- hilo_rdata  output  32  combinational read of HI (hilo_sel=1) or LO (hilo_sel=0), for MFHL
- hi_out  output  32  HI register
- lo_out  output  32  LO register

Behaviour:
- Reset (async, rst_n=0): HI=0, LO=0, count=0, busy_q=0, pending result=0. busy=0 while in reset; hilo_rdata=0.
- Reset asserted mid-operation: the operation is abandoned and HI/LO do not change after release.
- Accepted start: start=1, cancel=0, busy_q=0, sampled at edge E0.
  - At E0: capture result {hi_n, lo_n} computed from rs_val, rt_val and muldiv_op.
  - At E0: count <= MULT_CYCLES for op[1]=0, DIV_CYCLES for op[1]=1.
- busy_q = (count != 0). count decrements by 1 each edge while nonzero.
- At the edge where count goes 1->0, HI/LO are written with the pending result.
- Latency: with N = cycle count, busy_q is high for exactly N cycles after E0. The new HI/LO is visible in the cycle after the last busy cycle.
- busy is combinationally high in the start cycle, so a following dependent instruction stalls immediately.
- Arithmetic:
  - mult: signed 32x32 -> 64 product, HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div overflow case 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - divu: unsigned quotient and remainder.
  - Divide by zero: the full DIV_CYCLES still elapse; HI and LO are left unchanged.
- mthl (cancel=0, busy_q=0): the selected register <= rs_val at the edge; the other register is unchanged.
- start while busy_q=1: ignored, with no effect on the in-flight operation. Simulation assertion fires; hazard logic must prevent this case.
- mthl while busy_q=1: ignored, with an assertion.
- start and mthl both set in the same cycle: start wins and mthl is dropped. Never produced by the decoder.
- cancel=1: start and mthl are ignored that cycle. An operation already in flight continues to completion, because it belongs to an older, committed instruction.
- hilo_rdata shows current register contents; it is not forwarded from an in-flight result. Stall guarantees MFHL never reads while busy.
- Back-to-back: a new start is accepted in the cycle after the write edge (busy_q=0).

Decomposition:
- muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - HILO_LO / HILO_HI select constants;
  - default MULT_CYCLES / DIV_CYCLES.
- One combinational sub-module, muldiv_core: (a, b, op) -> {hi_n, lo_n, div_by_zero}. It isolates the signed/unsigned and divide corner cases.
- Counter, pending registers and HI/LO stay in muldiv_unit.

Test Plan:
- Reset: rst_n=0 asynchronously mid-mult (count=3) -> busy=0 immediately; hi_out=lo_out=0; after release HI/LO remain 0 indefinitely.
- mult rs=0xFFFFFFFE (-2), rt=3, start 1 cycle -> busy high start cycle + 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div -7/2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu 5/0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles; then HI=0x11, LO=0x22 unchanged.
- mthl hilo_sel=1, rs=0xDEADBEEF -> next cycle hi_out=0xDEADBEEF, LO unchanged, hilo_rdata (sel=1)=0xDEADBEEF.
- start with cancel=1 -> busy=0 and HI/LO unchanged.
- start during busy_q -> ignored; the original result lands on schedule.
- mthl during busy_q -> dropped.
